bt_radio: RTL and testbench

//  Behavioural 2.4 GHz Bluetooth radio front-end model between the link controller (bt_top) and a peer radio.
//  It holds a synthesiser channel, gates the 1 Mb/s TX bitstream onto the air and advertises the channel on txfk.
//  It passes peer air bits to the LC only when RX is enabled, the synthesiser is locked and the peer channel equals ours.

---
 rtl/bt_radio.sv | 107 ++++++++++
 tb/tb_bt_radio.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_radio.sv
// Behavioural 2.4 GHz Bluetooth radio front-end model.
// Holds a synthesiser channel and gates the 1 Mb/s TX bitstream onto the air.
// Peer air bits reach the LC only when RX is enabled, the synth is locked and the
// peer channel matches ours.
module bt_radio #(
  parameter int         PLL_LOCK_US = 0,
  parameter int         BIT_DLY_US  = 1,
  parameter logic [6:0] NOCH        = 7'd127
) (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        p_1us,
  input  logic        connsactive,
  input  logic [27:0] CLK,
  input  logic        txbitin,
  input  logic        rxbitin,
  input  logic        txen,
  input  logic        rxen,
  input  logic [6:0]  lc_fk,
  input  logic [6:0]  rxfk,
  input  logic        loadfreq_p,
  output logic        txbitout,
  output logic        rxbitout,
  output logic [6:0]  txfk
);

  localparam int               CNT_W    = (PLL_LOCK_US < 2) ? 1 : $clog2(PLL_LOCK_US + 1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(PLL_LOCK_US);
  localparam logic [6:0]       MAX_CH   = 7'd78;

  logic [6:0]            synth_fk_q, synth_fk_d;
  logic                  locked_q, locked_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [BIT_DLY_US-1:0] tx_dly_q, tx_dly_d;
  logic [BIT_DLY_US-1:0] rx_dly_q, rx_dly_d;
  logic                  synth_legal;
  logic                  tx_ok;
  logic                  rx_ok;

  // Connection state and native clock are carried on the interface only.
  logic unused_inputs;
  assign unused_inputs = ^{connsactive, CLK};

  // Path gating: the receive side also demands the peer is on a legal channel.
  always_comb begin
    synth_legal = (synth_fk_q <= MAX_CH);
    tx_ok       = txen & locked_q;
    rx_ok       = rxen & locked_q & (rxfk == synth_fk_q) & (rxfk <= MAX_CH);
  end

  // Synthesiser: a load restarts the settle count; an illegal channel never locks.
  always_comb begin
    synth_fk_d = synth_fk_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    if (loadfreq_p) begin
      synth_fk_d = lc_fk;
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end else if (!locked_q && synth_legal) begin
      if (lock_cnt_q == LOCK_TGT) begin
        locked_d = 1'b1;
      end else if (p_1us) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end
  end

  // Air-latency delay lines advance on the bit clock; gated-off paths shift in zeros.
  always_comb begin
    tx_dly_d = tx_dly_q;
    rx_dly_d = rx_dly_q;
    if (p_1us) begin
      tx_dly_d[0] = tx_ok & txbitin;
      rx_dly_d[0] = rx_ok & rxbitin;
      for (int i = 1; i < BIT_DLY_US; i++) begin
        tx_dly_d[i] = tx_dly_q[i-1];
        rx_dly_d[i] = rx_dly_q[i-1];
      end
    end
  end

  // State registers; everything clears so no unknown value ever reaches the air.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      synth_fk_q <= NOCH;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      tx_dly_q   <= '0;
      rx_dly_q   <= '0;
    end else begin
      synth_fk_q <= synth_fk_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      tx_dly_q   <= tx_dly_d;
      rx_dly_q   <= rx_dly_d;
    end
  end

  // Outputs: line tails, and the on-air channel advertised only while transmitting.
  always_comb begin
    txbitout = tx_dly_q[BIT_DLY_US-1];
    rxbitout = rx_dly_q[BIT_DLY_US-1];
    txfk     = tx_ok ? synth_fk_q : NOCH;
  end

endmodule

// File: tb/tb_bt_radio.sv
// Bench for bt_radio: two cross-wired radios (A transmits, B receives) plus a third
// instance with a slow PLL and a deeper air delay.
module tb_bt_radio;

  logic        clk = 1'b0;
  logic        rstz;
  logic        p_1us;
  logic        conns;
  logic [27:0] btclk;

  logic       a_txbit, a_txen, a_rxen, a_load;
  logic [6:0] a_lcfk;
  logic       a_txout, a_rxout;
  logic [6:0] a_txfk;

  logic       b_txbit, b_txen, b_rxen, b_load;
  logic [6:0] b_lcfk;
  logic       b_txout, b_rxout;
  logic [6:0] b_txfk;

  logic       c_txbit, c_rxbit, c_txen, c_rxen, c_load;
  logic [6:0] c_lcfk, c_rxfk;
  logic       c_txout, c_rxout;
  logic [6:0] c_txfk;

  int checks   = 0;
  int failures = 0;

  logic       qa[$];
  logic       qb[$];
  logic [6:0] qfk[$];
  logic       qc[$];

  always #5 clk = ~clk;

  bt_radio #(.PLL_LOCK_US(0), .BIT_DLY_US(1)) u_a (
    .clk_6M(clk), .rstz(rstz), .p_1us(p_1us), .connsactive(conns), .CLK(btclk),
    .txbitin(a_txbit), .rxbitin(b_txout), .txen(a_txen), .rxen(a_rxen),
    .lc_fk(a_lcfk), .rxfk(b_txfk), .loadfreq_p(a_load),
    .txbitout(a_txout), .rxbitout(a_rxout), .txfk(a_txfk)
  );

  bt_radio #(.PLL_LOCK_US(0), .BIT_DLY_US(1)) u_b (
    .clk_6M(clk), .rstz(rstz), .p_1us(p_1us), .connsactive(conns), .CLK(btclk),
    .txbitin(b_txbit), .rxbitin(a_txout), .txen(b_txen), .rxen(b_rxen),
    .lc_fk(b_lcfk), .rxfk(a_txfk), .loadfreq_p(b_load),
    .txbitout(b_txout), .rxbitout(b_rxout), .txfk(b_txfk)
  );

  bt_radio #(.PLL_LOCK_US(5), .BIT_DLY_US(3)) u_c (
    .clk_6M(clk), .rstz(rstz), .p_1us(p_1us), .connsactive(conns), .CLK(btclk),
    .txbitin(c_txbit), .rxbitin(c_rxbit), .txen(c_txen), .rxen(c_rxen),
    .lc_fk(c_lcfk), .rxfk(c_rxfk), .loadfreq_p(c_load),
    .txbitout(c_txout), .rxbitout(c_rxout), .txfk(c_txfk)
  );

  typedef struct {
    logic       al;     // load A
    logic [6:0] afk;
    logic       bl;     // load B
    logic [6:0] bfk;
    logic       atxen;
    logic       brxen;
    logic       tx;     // A txbitin
    logic       eatx;   // expected A txbitout after the tick
    logic       ebrx;   // expected B rxbitout after the tick
    logic [6:0] eafk;   // expected A txfk after the tick
  } vec_t;

  vec_t tbl[19];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge with inputs already set: one bit-clock strobe.
  task automatic do_tick();
    p_1us = 1'b1;
    @(negedge clk);
    p_1us = 1'b0;
  endtask

  task automatic sb_c(input string nm);
    logic e;
    if (qc.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = qc.pop_front();
      chk1(nm, c_txout, e);
    end
  endtask

  // C tick: expected bit is pushed as the stimulus goes in, popped once the line has moved.
  task automatic c_tick(input logic b, input logic ok, input logic [6:0] efk, input string nm);
    c_txbit = b;
    qc.push_back(ok & b);
    do_tick();
    sb_c(nm);
    chk7({nm, "_fk"}, c_txfk, efk);
    idle(5);
  endtask

  task automatic pulse_load_c(input logic [6:0] fk);
    c_lcfk = fk;
    c_load = 1'b1;
    @(negedge clk);
    c_load = 1'b0;
    idle(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    rstz = 1'b0; p_1us = 1'b0; conns = 1'b0; btclk = 28'h0;
    a_txbit = 0; a_txen = 0; a_rxen = 0; a_load = 0; a_lcfk = 7'd0;
    b_txbit = 0; b_txen = 0; b_rxen = 0; b_load = 0; b_lcfk = 7'd0;
    c_txbit = 0; c_rxbit = 0; c_txen = 0; c_rxen = 0; c_load = 0;
    c_lcfk = 7'd0; c_rxfk = 7'd0;

    //                al  afk     bl  bfk    atx brx tx  eatx ebrx eafk
    tbl[0]  = '{1'b1, 7'd23, 1'b1, 7'd50, 1, 1, 1, 1, 0, 7'd23};
    tbl[1]  = '{1'b0, 7'd23, 1'b0, 7'd50, 1, 1, 0, 0, 0, 7'd23};
    tbl[2]  = '{1'b0, 7'd23, 1'b0, 7'd50, 1, 1, 1, 1, 0, 7'd23};
    tbl[3]  = '{1'b0, 7'd23, 1'b0, 7'd50, 1, 1, 1, 1, 0, 7'd23};
    tbl[4]  = '{1'b0, 7'd23, 1'b0, 7'd50, 0, 1, 1, 0, 0, 7'd127};
    tbl[5]  = '{1'b1, 7'd40, 1'b1, 7'd40, 1, 1, 1, 1, 0, 7'd40};
    tbl[6]  = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 1, 1, 1, 7'd40};
    tbl[7]  = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 0, 0, 1, 7'd40};
    tbl[8]  = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 1, 1, 0, 7'd40};
    tbl[9]  = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 0, 0, 1, 7'd40};
    tbl[10] = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 0, 0, 0, 7'd40};
    tbl[11] = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 1, 1, 0, 7'd40};
    tbl[12] = '{1'b0, 7'd40, 1'b1, 7'd41, 1, 1, 1, 1, 0, 7'd40};
    tbl[13] = '{1'b0, 7'd40, 1'b0, 7'd41, 1, 1, 0, 0, 0, 7'd40};
    tbl[14] = '{1'b0, 7'd40, 1'b0, 7'd41, 1, 1, 1, 1, 0, 7'd40};
    tbl[15] = '{1'b0, 7'd40, 1'b1, 7'd40, 1, 0, 0, 0, 0, 7'd40};
    tbl[16] = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 1, 1, 0, 7'd40};
    tbl[17] = '{1'b0, 7'd40, 1'b0, 7'd40, 1, 1, 1, 1, 1, 7'd40};
    tbl[18] = '{1'b0, 7'd40, 1'b0, 7'd40, 0, 1, 1, 0, 0, 7'd127};

    // Reset state
    idle(3);
    chk1("rst_a_tx", a_txout, 1'b0);
    chk7("rst_a_fk", a_txfk, 7'd127);
    chk1("rst_b_rx", b_rxout, 1'b0);
    chk7("rst_c_fk", c_txfk, 7'd127);
    rstz = 1'b1;
    idle(2);

    // Table-driven link vectors
    for (int i = 0; i < 19; i++) begin
      logic ea, eb;
      logic [6:0] ef;
      if (tbl[i].al || tbl[i].bl) begin
        a_lcfk = tbl[i].afk; b_lcfk = tbl[i].bfk;
        a_load = tbl[i].al;  b_load = tbl[i].bl;
        @(negedge clk);
        a_load = 1'b0; b_load = 1'b0;
        idle(2);
      end
      a_txen = tbl[i].atxen; b_rxen = tbl[i].brxen; a_txbit = tbl[i].tx;
      qa.push_back(tbl[i].eatx);
      qb.push_back(tbl[i].ebrx);
      qfk.push_back(tbl[i].eafk);
      do_tick();
      ea = qa.pop_front(); eb = qb.pop_front(); ef = qfk.pop_front();
      chk1($sformatf("vec%0d_a_tx", i), a_txout, ea);
      chk1($sformatf("vec%0d_b_rx", i), b_rxout, eb);
      chk7($sformatf("vec%0d_a_fk", i), a_txfk, ef);
      idle(5);
    end

    // Reload A mid-transmission: the in-flight bit stays, channel drops while unlocked
    a_txen = 1'b1; a_txbit = 1'b1;
    do_tick();
    chk1("mid_pre_tx", a_txout, 1'b1);
    a_lcfk = 7'd30; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    chk7("mid_unlock_fk", a_txfk, 7'd127);
    chk1("mid_inflight", a_txout, 1'b1);
    @(negedge clk);
    chk7("mid_relock_fk", a_txfk, 7'd30);
    idle(3);
    a_txbit = 1'b0;
    do_tick();
    chk1("mid_post_tx", a_txout, 1'b0);
    chk1("mid_b_mismatch", b_rxout, 1'b0);
    idle(5);

    // Slow PLL: load coinciding with a tick must not count that tick
    c_txen = 1'b1;
    qc.delete();
    qc.push_back(1'b0);
    qc.push_back(1'b0);
    c_lcfk = 7'd10; c_load = 1'b1; c_txbit = 1'b1;
    qc.push_back(1'b0);
    do_tick();
    c_load = 1'b0;
    sb_c("pll_t0");
    chk7("pll_t0_fk", c_txfk, 7'd127);
    idle(5);
    for (int k = 1; k <= 5; k++) c_tick(1'b1, 1'b0, 7'd127, $sformatf("pll_t%0d", k));
    chk7("pll_locked_fk", c_txfk, 7'd10);
    pat = 4'b1101;
    for (int k = 0; k < 4; k++) c_tick(pat[k], 1'b1, 7'd10, $sformatf("pll_d%0d", k));
    c_tick(1'b0, 1'b1, 7'd10, "pll_d4");
    c_tick(1'b0, 1'b1, 7'd10, "pll_d5");
    chk1("c_rx_idle", c_rxout, 1'b0);

    // Illegal channel never locks; a legal reload recovers
    pulse_load_c(7'd100);
    for (int k = 0; k < 8; k++) c_tick(1'b1, 1'b0, 7'd127, $sformatf("ill_t%0d", k));
    pulse_load_c(7'd5);
    for (int k = 0; k < 5; k++) c_tick(1'b1, 1'b0, 7'd127, $sformatf("rec_t%0d", k));
    chk7("rec_locked_fk", c_txfk, 7'd5);
    for (int k = 0; k < 4; k++) c_tick(1'b1, 1'b1, 7'd5, $sformatf("rec_d%0d", k));

    // Asynchronous reset mid-stream
    a_lcfk = 7'd40; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    idle(2);
    a_txbit = 1'b1;
    do_tick();
    idle(5);
    do_tick();
    chk1("pre_rst_a_tx", a_txout, 1'b1);
    chk1("pre_rst_b_rx", b_rxout, 1'b1);
    #3;
    rstz = 1'b0;
    #1;
    chk1("async_a_tx", a_txout, 1'b0);
    chk1("async_b_rx", b_rxout, 1'b0);
    chk7("async_a_fk", a_txfk, 7'd127);
    chk7("async_c_fk", c_txfk, 7'd127);
    @(negedge clk);
    do_tick();
    chk1("hold_a_tx", a_txout, 1'b0);
    chk7("hold_a_fk", a_txfk, 7'd127);
    rstz = 1'b1;
    idle(2);
    do_tick();
    chk7("post_rst_fk", a_txfk, 7'd127);
    chk1("post_rst_tx", a_txout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
